// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - control-word bit map, FSM state and command encodings for the memory stage
package mem_stage_pkg;

  localparam int CTL_W          = 10;
  localparam int CTL_REG_WRITE  = 0;
  localparam int CTL_MEM_TO_REG = 1;
  localparam int CTL_MEM_READ   = 2;
  localparam int CTL_MEM_WRITE  = 3;
  localparam int CTL_PUSH       = 4;
  localparam int CTL_POP        = 5;
  localparam int CTL_CALL       = 6;
  localparam int CTL_RET        = 7;
  localparam int CTL_OUT_EN     = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_t;

  // Winning memory operation after priority resolution of the control word.
  typedef enum logic [2:0] {
    OP_NONE,
    OP_READ,
    OP_WRITE,
    OP_PUSH,
    OP_POP,
    OP_CALL,
    OP_RET
  } op_t;

  typedef enum logic [2:0] {
    SP_HOLD,
    SP_INC1,
    SP_DEC1,
    SP_INC2,
    SP_DEC2
  } sp_cmd_t;

endpackage

// File: rtl/stack_ptr_unit.sv
// rtl/stack_ptr_unit.sv - stack pointer register with +/-1 and +/-2 modulo updates
module stack_ptr_unit
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int SP_INIT = 2**ADDR_W-1
) (
  input  logic              clk,
  input  logic              rst,
  input  sp_cmd_t           cmd,
  output logic [ADDR_W-1:0] sp
);

  // Arithmetic wraps modulo 2**ADDR_W; there is deliberately no overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= ADDR_W'(SP_INIT);
    end else begin
      case (cmd)
        SP_INC1: sp <= sp + ADDR_W'(1);
        SP_DEC1: sp <= sp - ADDR_W'(1);
        SP_INC2: sp <= sp + ADDR_W'(2);
        SP_DEC2: sp <= sp - ADDR_W'(2);
        default: sp <= sp;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory-stage controller: load/store, push/pop, two-word call/ret
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int SP_INIT = 2**ADDR_W-1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTL_W-1:0]  controlSignals_in,
  input  logic [15:0]       ALUData_in,
  input  logic [15:0]       ReadData2_in,
  input  logic [2:0]        WriteAdd_in,
  input  logic [31:0]       PC_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  input  logic [15:0]       mem_rdata,
  output logic              stall_o,
  output logic [CTL_W-1:0]  controlSignals_out,
  output logic [15:0]       ALUData_out,
  output logic [15:0]       MemData_out,
  output logic [2:0]        WriteAdd_out,
  output logic [31:0]       PC_out,
  output logic              pc_load_o,
  output logic [ADDR_W-1:0] sp_o
);

  state_t            state, state_nxt;
  op_t               op_in;
  sp_cmd_t           sp_cmd;
  logic [ADDR_W-1:0] sp, sp_p1, sp_p2, sp_m1;
  logic [CTL_W-1:0]  ctl_cap;
  logic              sec_is_ret;
  logic [15:0]       pc_lo_lat;
  logic              rw_lat;

  stack_ptr_unit #(
    .ADDR_W  (ADDR_W),
    .SP_INIT (SP_INIT)
  ) u_sp (
    .clk (clk),
    .rst (rst),
    .cmd (sp_cmd),
    .sp  (sp)
  );

  assign sp_p1 = sp + ADDR_W'(1);
  assign sp_p2 = sp + ADDR_W'(2);
  assign sp_m1 = sp - ADDR_W'(1);
  assign sp_o  = sp;

  // Resolve the winning op and form the cycle-1 capture word (reg_write withheld for call/ret).
  always_comb begin
    op_in = OP_NONE;
    if (controlSignals_in[CTL_CALL])           op_in = OP_CALL;
    else if (controlSignals_in[CTL_RET])       op_in = OP_RET;
    else if (controlSignals_in[CTL_PUSH])      op_in = OP_PUSH;
    else if (controlSignals_in[CTL_POP])       op_in = OP_POP;
    else if (controlSignals_in[CTL_MEM_WRITE]) op_in = OP_WRITE;
    else if (controlSignals_in[CTL_MEM_READ])  op_in = OP_READ;
    ctl_cap = controlSignals_in;
    if (op_in == OP_CALL || op_in == OP_RET) ctl_cap[CTL_REG_WRITE] = 1'b0;
  end

  // Next state, memory port, stall and SP command; reset silences every strobe.
  always_comb begin
    state_nxt = state;
    mem_addr  = sp;
    mem_wdata = '0;
    mem_we    = 1'b0;
    stall_o   = 1'b0;
    sp_cmd    = SP_HOLD;
    if (!rst) begin
      case (state)
        IDLE: begin
          case (op_in)
            OP_READ: mem_addr = ALUData_in[ADDR_W-1:0];
            OP_WRITE: begin
              mem_addr  = ALUData_in[ADDR_W-1:0];
              mem_wdata = ReadData2_in;
              mem_we    = 1'b1;
            end
            OP_PUSH: begin
              mem_wdata = ReadData2_in;
              mem_we    = 1'b1;
              sp_cmd    = SP_DEC1;
            end
            OP_POP: begin
              mem_addr = sp_p1;
              sp_cmd   = SP_INC1;
            end
            OP_CALL: begin
              mem_wdata = PC_in[31:16];
              mem_we    = 1'b1;
              stall_o   = 1'b1;
              state_nxt = SECOND;
            end
            OP_RET: begin
              mem_addr  = sp_p1;
              stall_o   = 1'b1;
              state_nxt = SECOND;
            end
            default: ;
          endcase
        end
        SECOND: begin
          state_nxt = IDLE;
          if (sec_is_ret) begin
            mem_addr = sp_p2;
            sp_cmd   = SP_INC2;
          end else begin
            mem_addr  = sp_m1;
            mem_wdata = pc_lo_lat;
            mem_we    = 1'b1;
            sp_cmd    = SP_DEC2;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // M/W outputs: captured in IDLE, held through SECOND except reg_write and the popped PC high half.
  always_ff @(posedge clk) begin
    if (rst) begin
      controlSignals_out <= '0;
      ALUData_out        <= '0;
      MemData_out        <= '0;
      WriteAdd_out       <= '0;
      PC_out             <= '0;
      pc_load_o          <= 1'b0;
      sec_is_ret         <= 1'b0;
      pc_lo_lat          <= '0;
      rw_lat             <= 1'b0;
    end else begin
      pc_load_o <= 1'b0;
      if (state == IDLE) begin
        controlSignals_out <= ctl_cap;
        ALUData_out        <= ALUData_in;
        WriteAdd_out       <= WriteAdd_in;
        rw_lat             <= controlSignals_in[CTL_REG_WRITE];
        case (op_in)
          OP_READ, OP_POP: MemData_out <= mem_rdata;
          OP_CALL: begin
            pc_lo_lat  <= PC_in[15:0];
            sec_is_ret <= 1'b0;
          end
          OP_RET: begin
            PC_out[15:0] <= mem_rdata;
            sec_is_ret   <= 1'b1;
          end
          default: ;
        endcase
      end else begin
        controlSignals_out[CTL_REG_WRITE] <= rw_lat;
        if (sec_is_ret) begin
          PC_out[31:16] <= mem_rdata;
          pc_load_o     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - self-checking bench for mem_stage_ctrl with a behavioural stack/memory model
module tb_mem_stage_ctrl;

  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst;
  logic [9:0]  ctl;
  logic [15:0] alu, rd2;
  logic [2:0]  wa;
  logic [31:0] pc;

  logic [AW-1:0] mem_addr, sp;
  logic [15:0]   mem_wdata, mem_rdata, alu_out, md_out;
  logic          mem_we, stall, pc_load;
  logic [9:0]    ctl_out;
  logic [2:0]    wa_out;
  logic [31:0]   pc_out;

  logic [AW-1:0] w_addr, w_sp;
  logic [15:0]   w_wdata, w_rdata, w_alu_out, w_md_out;
  logic          w_we, w_stall, w_pc_load;
  logic [9:0]    w_ctl_out;
  logic [2:0]    w_wa_out;
  logic [31:0]   w_pc_out;

  logic [15:0] mem   [0:4095] = '{default: 16'h0000};
  logic [15:0] mem_w [0:4095] = '{default: 16'h0000};
  logic [15:0] ref_mem [0:4095];

  int n_pass = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  always @(posedge clk) if (w_we) mem_w[w_addr] <= w_wdata;
  assign mem_rdata = mem[mem_addr];
  assign w_rdata   = mem_w[w_addr];

  mem_stage_ctrl #(.ADDR_W(AW)) u_dut (
    .clk(clk), .rst(rst), .controlSignals_in(ctl), .ALUData_in(alu), .ReadData2_in(rd2),
    .WriteAdd_in(wa), .PC_in(pc), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .stall_o(stall), .controlSignals_out(ctl_out), .ALUData_out(alu_out),
    .MemData_out(md_out), .WriteAdd_out(wa_out), .PC_out(pc_out), .pc_load_o(pc_load), .sp_o(sp)
  );

  mem_stage_ctrl #(.ADDR_W(AW), .SP_INIT(0)) u_dut_w (
    .clk(clk), .rst(rst), .controlSignals_in(ctl), .ALUData_in(alu), .ReadData2_in(rd2),
    .WriteAdd_in(wa), .PC_in(pc), .mem_addr(w_addr), .mem_wdata(w_wdata), .mem_we(w_we),
    .mem_rdata(w_rdata), .stall_o(w_stall), .controlSignals_out(w_ctl_out), .ALUData_out(w_alu_out),
    .MemData_out(w_md_out), .WriteAdd_out(w_wa_out), .PC_out(w_pc_out), .pc_load_o(w_pc_load), .sp_o(w_sp)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ctl = '0; alu = '0; rd2 = '0; wa = '0; pc = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ctl = 10'h048; alu = 16'h0100; rd2 = 16'h1234; pc = 32'hFFFF_FFFF; wa = 3'd7;
    #1;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL rst_we_gated got %b exp 0", mem_we); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL rst_stall_gated got %b exp 0", stall); else n_pass++;
    step();
    n_checks++; if (sp !== 12'hFFF) $display("FAIL rst_sp got %h exp fff", sp); else n_pass++;
    n_checks++; if (w_sp !== 12'h000) $display("FAIL rst_sp_w got %h exp 000", w_sp); else n_pass++;
    n_checks++; if (ctl_out !== 10'h0) $display("FAIL rst_ctl got %h exp 0", ctl_out); else n_pass++;
    n_checks++; if (alu_out !== 16'h0) $display("FAIL rst_alu got %h exp 0", alu_out); else n_pass++;
    n_checks++; if (md_out !== 16'h0) $display("FAIL rst_md got %h exp 0", md_out); else n_pass++;
    n_checks++; if (wa_out !== 3'h0) $display("FAIL rst_wa got %h exp 0", wa_out); else n_pass++;
    n_checks++; if (pc_out !== 32'h0) $display("FAIL rst_pc got %h exp 0", pc_out); else n_pass++;
    n_checks++; if (pc_load !== 1'b0) $display("FAIL rst_pcload got %b exp 0", pc_load); else n_pass++;
    ctl = '0;
    #1;
    n_checks++; if (mem_addr !== 12'hFFF) $display("FAIL idle_addr_sp got %h exp fff", mem_addr); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_store_load();
    do_reset();
    ctl = 10'h008; alu = 16'h0010; rd2 = 16'hBEEF; wa = 3'd2;
    #1;
    n_checks++; if (mem_we !== 1'b1) $display("FAIL st_we got %b exp 1", mem_we); else n_pass++;
    n_checks++; if (mem_addr !== 12'h010) $display("FAIL st_addr got %h exp 010", mem_addr); else n_pass++;
    n_checks++; if (mem_wdata !== 16'hBEEF) $display("FAIL st_wdata got %h exp beef", mem_wdata); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL st_stall got %b exp 0", stall); else n_pass++;
    step();
    ctl = 10'h007; alu = 16'h0010; rd2 = 16'h0; wa = 3'd3;
    #1;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL ld_we got %b exp 0", mem_we); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL ld_stall got %b exp 0", stall); else n_pass++;
    step();
    n_checks++; if (md_out !== 16'hBEEF) $display("FAIL ld_data got %h exp beef", md_out); else n_pass++;
    n_checks++; if (ctl_out !== 10'h007) $display("FAIL ld_ctl got %h exp 007", ctl_out); else n_pass++;
    n_checks++; if (wa_out !== 3'd3) $display("FAIL ld_wa got %h exp 3", wa_out); else n_pass++;
    ctl = '0;
  endtask

  task automatic test_push_pop();
    do_reset();
    ctl = 10'h010; rd2 = 16'h1234;
    #1;
    n_checks++; if (mem_addr !== 12'hFFF) $display("FAIL push_addr got %h exp fff", mem_addr); else n_pass++;
    n_checks++; if (mem_we !== 1'b1) $display("FAIL push_we got %b exp 1", mem_we); else n_pass++;
    step();
    n_checks++; if (sp !== 12'hFFE) $display("FAIL push_sp got %h exp ffe", sp); else n_pass++;
    ctl = 10'h020; rd2 = 16'h0;
    #1;
    n_checks++; if (mem_addr !== 12'hFFF) $display("FAIL pop_addr got %h exp fff", mem_addr); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL pop_we got %b exp 0", mem_we); else n_pass++;
    step();
    n_checks++; if (md_out !== 16'h1234) $display("FAIL pop_data got %h exp 1234", md_out); else n_pass++;
    n_checks++; if (sp !== 12'hFFF) $display("FAIL pop_sp got %h exp fff", sp); else n_pass++;
    ctl = '0;
  endtask

  task automatic test_call_ret();
    do_reset();
    ctl = 10'h041; pc = 32'hDEAD_BEEF; alu = 16'h0777; wa = 3'd5;
    #1;
    n_checks++; if (stall !== 1'b1) $display("FAIL call1_stall got %b exp 1", stall); else n_pass++;
    n_checks++; if (mem_addr !== 12'hFFF) $display("FAIL call1_addr got %h exp fff", mem_addr); else n_pass++;
    n_checks++; if (mem_wdata !== 16'hDEAD) $display("FAIL call1_wdata got %h exp dead", mem_wdata); else n_pass++;
    step();
    n_checks++; if (ctl_out !== 10'h040) $display("FAIL call1_ctl got %h exp 040", ctl_out); else n_pass++;
    ctl = 10'h010; pc = 32'h0; alu = 16'h1111; rd2 = 16'h9999; wa = 3'd1;
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL call2_stall got %b exp 0", stall); else n_pass++;
    n_checks++; if (mem_addr !== 12'hFFE) $display("FAIL call2_addr got %h exp ffe", mem_addr); else n_pass++;
    n_checks++; if (mem_wdata !== 16'hBEEF) $display("FAIL call2_wdata got %h exp beef", mem_wdata); else n_pass++;
    step();
    n_checks++; if (sp !== 12'hFFD) $display("FAIL call_sp got %h exp ffd", sp); else n_pass++;
    n_checks++; if (ctl_out !== 10'h041) $display("FAIL call2_ctl got %h exp 041", ctl_out); else n_pass++;
    n_checks++; if (alu_out !== 16'h0777) $display("FAIL call_alu_hold got %h exp 0777", alu_out); else n_pass++;
    n_checks++; if (mem[12'hFFF] !== 16'hDEAD) $display("FAIL call_mem_hi got %h exp dead", mem[12'hFFF]); else n_pass++;
    ctl = 10'h080; alu = 16'h0;
    #1;
    n_checks++; if (stall !== 1'b1) $display("FAIL ret1_stall got %b exp 1", stall); else n_pass++;
    n_checks++; if (mem_addr !== 12'hFFE) $display("FAIL ret1_addr got %h exp ffe", mem_addr); else n_pass++;
    step();
    n_checks++; if (pc_load !== 1'b0) $display("FAIL ret1_pcload got %b exp 0", pc_load); else n_pass++;
    ctl = 10'h008;
    #1;
    n_checks++; if (mem_addr !== 12'hFFF) $display("FAIL ret2_addr got %h exp fff", mem_addr); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL ret2_we got %b exp 0", mem_we); else n_pass++;
    step();
    n_checks++; if (pc_out !== 32'hDEAD_BEEF) $display("FAIL ret_pc got %h exp deadbeef", pc_out); else n_pass++;
    n_checks++; if (pc_load !== 1'b1) $display("FAIL ret_pcload got %b exp 1", pc_load); else n_pass++;
    n_checks++; if (sp !== 12'hFFF) $display("FAIL ret_sp got %h exp fff", sp); else n_pass++;
    ctl = '0;
    step();
    n_checks++; if (pc_load !== 1'b0) $display("FAIL ret_pcload_pulse got %b exp 0", pc_load); else n_pass++;
  endtask

  task automatic test_priority();
    do_reset();
    ctl = 10'h008; alu = 16'h0123; rd2 = 16'h5A5A;
    step();
    ctl = 10'h048; alu = 16'h0123; rd2 = 16'h1111; pc = 32'h1234_5678;
    #1;
    n_checks++; if (mem_addr !== 12'hFFF) $display("FAIL prio_addr got %h exp fff", mem_addr); else n_pass++;
    n_checks++; if (mem_wdata !== 16'h1234) $display("FAIL prio_wdata got %h exp 1234", mem_wdata); else n_pass++;
    step();
    ctl = '0;
    #1;
    n_checks++; if (mem_wdata !== 16'h5678) $display("FAIL prio_wdata2 got %h exp 5678", mem_wdata); else n_pass++;
    step();
    n_checks++; if (mem[12'h123] !== 16'h5A5A) $display("FAIL prio_nostore got %h exp 5a5a", mem[12'h123]); else n_pass++;
    n_checks++; if (ctl_out !== 10'h048) $display("FAIL prio_ctl got %h exp 048", ctl_out); else n_pass++;
    n_checks++; if (sp !== 12'hFFD) $display("FAIL prio_sp got %h exp ffd", sp); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    ctl = 10'h008; alu = 16'h0FFE; rd2 = 16'h5555;
    step();
    ctl = 10'h041; alu = 16'h0ABC; pc = 32'hCAFE_F00D; wa = 3'd6;
    step();
    rst = 1'b1;
    #1;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL mid_we got %b exp 0", mem_we); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL mid_stall got %b exp 0", stall); else n_pass++;
    step();
    rst = 1'b0; ctl = 10'h010; rd2 = 16'h7777;
    #1;
    n_checks++; if (mem_addr !== 12'hFFF) $display("FAIL mid_idle_addr got %h exp fff", mem_addr); else n_pass++;
    n_checks++; if (mem_wdata !== 16'h7777) $display("FAIL mid_idle_wdata got %h exp 7777", mem_wdata); else n_pass++;
    n_checks++; if (sp !== 12'hFFF) $display("FAIL mid_sp got %h exp fff", sp); else n_pass++;
    n_checks++; if (mem[12'hFFE] !== 16'h5555) $display("FAIL mid_nowrite got %h exp 5555", mem[12'hFFE]); else n_pass++;
    n_checks++; if (mem[12'hFFF] !== 16'hCAFE) $display("FAIL mid_first got %h exp cafe", mem[12'hFFF]); else n_pass++;
    n_checks++; if (ctl_out !== 10'h0) $display("FAIL mid_ctl got %h exp 0", ctl_out); else n_pass++;
    n_checks++; if (alu_out !== 16'h0) $display("FAIL mid_alu got %h exp 0", alu_out); else n_pass++;
    n_checks++; if (wa_out !== 3'h0) $display("FAIL mid_wa got %h exp 0", wa_out); else n_pass++;
    ctl = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    ctl = 10'h010; rd2 = 16'hAAAA;
    #1;
    n_checks++; if (w_addr !== 12'h000) $display("FAIL wrap_push_addr got %h exp 000", w_addr); else n_pass++;
    n_checks++; if (w_we !== 1'b1) $display("FAIL wrap_push_we got %b exp 1", w_we); else n_pass++;
    step();
    n_checks++; if (w_sp !== 12'hFFF) $display("FAIL wrap_push_sp got %h exp fff", w_sp); else n_pass++;
    ctl = 10'h020;
    #1;
    n_checks++; if (w_addr !== 12'h000) $display("FAIL wrap_pop_addr got %h exp 000", w_addr); else n_pass++;
    n_checks++; if (w_stall !== 1'b0) $display("FAIL wrap_stall got %b exp 0", w_stall); else n_pass++;
    step();
    n_checks++; if (w_md_out !== 16'hAAAA) $display("FAIL wrap_pop_data got %h exp aaaa", w_md_out); else n_pass++;
    n_checks++; if (w_sp !== 12'h000) $display("FAIL wrap_pop_sp got %h exp 000", w_sp); else n_pass++;
    n_checks++; if (w_ctl_out !== 10'h020) $display("FAIL wrap_ctl got %h exp 020", w_ctl_out); else n_pass++;
    ctl = '0;
  endtask

  task automatic test_random();
    int          rank [6] = '{6, 7, 4, 5, 3, 2};
    int          k, op;
    logic [31:0] r, exp_pc;
    logic [9:0]  c;
    logic [AW-1:0] ref_sp, ix, wad;
    logic [15:0] exp_md, wd, a_s, lo_s;
    logic [2:0]  w_s;
    logic        two, we1;
    do_reset();
    for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];
    ref_sp = 12'hFFF; exp_md = '0; exp_pc = '0;
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 6);
      r = $urandom;
      c = r[9:0];
      for (int j = 0; j < 6; j++) if (j < k) c[rank[j]] = 1'b0;
      if (k < 6) c[rank[k]] = 1'b1;
      if (c[6]) op = 5; else if (c[7]) op = 6; else if (c[4]) op = 3;
      else if (c[5]) op = 4; else if (c[3]) op = 2; else if (c[2]) op = 1; else op = 0;
      ctl = c; alu = 16'($urandom); rd2 = 16'($urandom); wa = 3'($urandom); pc = $urandom;
      a_s = alu; w_s = wa; lo_s = pc[15:0];
      two = (op == 5) || (op == 6);
      we1 = (op == 2) || (op == 3) || (op == 5);
      wad = (op == 2) ? alu[AW-1:0] : ref_sp;
      wd  = (op == 5) ? pc[31:16] : rd2;
      #1;
      n_checks++; if (stall !== two) $display("FAIL rnd_stall op=%0d got %b exp %b", op, stall, two); else n_pass++;
      n_checks++; if (mem_we !== we1) $display("FAIL rnd_we op=%0d got %b exp %b", op, mem_we, we1); else n_pass++;
      if (we1) begin
        n_checks++; if (mem_addr !== wad) $display("FAIL rnd_waddr op=%0d got %h exp %h", op, mem_addr, wad); else n_pass++;
      end
      case (op)
        1: exp_md = ref_mem[alu[AW-1:0]];
        2: ref_mem[alu[AW-1:0]] = rd2;
        3: begin ref_mem[ref_sp] = rd2; ref_sp = ref_sp - 12'd1; end
        4: begin ix = ref_sp + 12'd1; exp_md = ref_mem[ix]; ref_sp = ix; end
        5: begin
          ref_mem[ref_sp] = pc[31:16];
          ix = ref_sp - 12'd1; ref_mem[ix] = pc[15:0];
          ref_sp = ref_sp - 12'd2;
        end
        6: begin
          ix = ref_sp + 12'd1; exp_pc[15:0] = ref_mem[ix];
          ix = ref_sp + 12'd2; exp_pc[31:16] = ref_mem[ix];
          ref_sp = ref_sp + 12'd2;
        end
        default: ;
      endcase
      step();
      if (two) begin
        n_checks++; if (ctl_out[0] !== 1'b0) $display("FAIL rnd_rw_withheld got %b exp 0", ctl_out[0]); else n_pass++;
        ctl = 10'($urandom); alu = 16'($urandom); rd2 = 16'($urandom); pc = $urandom;
        #1;
        n_checks++; if (stall !== 1'b0) $display("FAIL rnd_stall2 got %b exp 0", stall); else n_pass++;
        n_checks++; if (mem_we !== (op == 5)) $display("FAIL rnd_we2 got %b exp %b", mem_we, (op == 5)); else n_pass++;
        if (op == 5) begin
          n_checks++; if (mem_wdata !== lo_s) $display("FAIL rnd_call_lo got %h exp %h", mem_wdata, lo_s); else n_pass++;
        end
        step();
      end
      n_checks++; if (ctl_out !== c) $display("FAIL rnd_ctl got %h exp %h", ctl_out, c); else n_pass++;
      n_checks++; if (alu_out !== a_s) $display("FAIL rnd_alu got %h exp %h", alu_out, a_s); else n_pass++;
      n_checks++; if (wa_out !== w_s) $display("FAIL rnd_wa got %h exp %h", wa_out, w_s); else n_pass++;
      n_checks++; if (md_out !== exp_md) $display("FAIL rnd_md op=%0d got %h exp %h", op, md_out, exp_md); else n_pass++;
      n_checks++; if (sp !== ref_sp) $display("FAIL rnd_sp op=%0d got %h exp %h", op, sp, ref_sp); else n_pass++;
      n_checks++; if (pc_out !== exp_pc) $display("FAIL rnd_pc got %h exp %h", pc_out, exp_pc); else n_pass++;
      n_checks++; if (pc_load !== (op == 6)) $display("FAIL rnd_pcload got %b exp %b", pc_load, (op == 6)); else n_pass++;
      if (we1) begin
        n_checks++; if (mem[wad] !== wd) $display("FAIL rnd_memword got %h exp %h", mem[wad], wd); else n_pass++;
      end
    end
    ctl = '0;
  endtask

  initial begin
    rst = 1'b1; ctl = '0; alu = '0; rd2 = '0; wa = '0; pc = '0;
    test_reset();
    test_store_load();
    test_push_pop();
    test_call_ret();
    test_priority();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
